mb_to_blocks_mono: RTL and testbench
====================================

# mb_to_blocks_mono

Downstream of the monochrome color-space stage in the JPEG compressor. Captures each 16x16 Y macroblock (scanline order, write-addressed) into an internal two-page buffer, then replays it to the DCT input as four 8x8 blocks (top-left, top-right, bottom-left, bottom-right), each in row-major order. Double buffering lets one macroblock fill while the previous one drains.

## Interface
- No parameters. Sizes are fixed: 16x16 macroblock, 8-bit samples, 2 pages.
- clk  in  1  single clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  block enable; low acts as a synchronous clear of all state except `overrun`.
- pre_first_in  in  1  one-cycle pulse marking the first sample of an incoming macroblock.
- din  in  8  Y sample, already sign-flipped (two's complement, -128..127).
- yaddr  in  8  write address within the 16x16 macroblock, {row[3:0], col[3:0]}.
- ywe  in  1  write strobe for `din` at `yaddr`.
- ready  out  1  a full page is available and the reader is idle.
- start  in  1  request to drain one macroblock; honoured only when `ready`=1.
- dout  out  8  output sample, registered.
- dv  out  1  `dout` valid.
- first_out  out  1  with `dv`, marks the first sample of a macroblock.
- last_out  out  1  with `dv`, marks the last sample (index 255).
- busy  out  1  reader not idle.
- overrun  out  1  sticky; set when an incoming macroblock was dropped. Cleared only by `rst`.

## Operation
- Writer:
  - On `pre_first_in`: if `full[wpage]`=1, set `drop`=1 and `overrun`=1. Otherwise set `drop`=0.
  - On `ywe` & !`drop`: write `din` to page `wpage` at `yaddr`.
  - On `ywe` & `yaddr`=8'hff & !`drop`: set `full[wpage]`=1 and toggle `wpage`.
  - On `ywe` & `yaddr`=8'hff & `drop`: clear `drop`. The page is not marked full.
- Reader FSM, states IDLE / READ / FLUSH:
  - IDLE -> READ when `start` & `full[rpage]`. The counter `rcnt` is cleared.
  - READ: issue read address {rpage, blk[1], row[2:0], blk[0], col[2:0]}, where `rcnt` = {blk[1:0], row[2:0], col[2:0]}. Increment `rcnt` each cycle.
  - READ -> FLUSH at `rcnt`=255. In that same cycle, clear `full[rpage]` and toggle `rpage`.
  - FLUSH -> IDLE after one cycle, which covers the RAM latency.
- If `full` set (writer) and `full` clear (reader) hit different pages in the same cycle, both take effect. They never hit the same page.
- Pages are consumed strictly in fill order.
- `start` while not `ready` is ignored. There is no queuing.
- `ready` = (state==IDLE) & `full[rpage]`. `busy` = (state!=IDLE).
- `en`=0 or `rst`: `full`=2'b00, `wpage`=0, `rpage`=0, `drop`=0, state=IDLE. A mid-macroblock abort discards partial data. `rst` additionally clears `overrun`.

## Timing
- Reset values: `ready`=0, `dout`=8'h00, `dv`=0, `first_out`=0, `last_out`=0, `busy`=0, `overrun`=0.
- Cycle 0: `start` sampled with `ready`=1.
- Cycles 1..256: addresses 0..255 issued.
- Cycles 2..257: `dv`=1 continuously (256 samples).
  - `first_out` at cycle 2; `last_out` at cycle 257.
- `busy` is high during cycles 1..257. `ready` can be high again at cycle 258 at the earliest.
- A page freed at cycle 256 may be written from cycle 257.
- Write-to-ready latency: `ready` rises 1 cycle after the `ywe` with `yaddr`=8'hff, if the reader is idle.
- Reader RAM read latency: 1 cycle, with registered output.

## Configuration
- Macro `MB2BLK_OVERRUN_CNT_EN`.
- Defined: adds output `overrun_cnt` [7:0], incremented on each dropped macroblock and saturating at 8'hff. Reset value 0; cleared only by `rst`.
- Not defined: the port and counter are absent. Only the sticky `overrun` exists.

## Structure
- Shared package `mb2blk_pkg`:
  - constants MB_SAMPLES=256, BLK_SIDE=8, PAGES=2;
  - FSM state enum {IDLE, READ, FLUSH}.
- One sub-module: `ram_512x8_w1r1`, a simple dual-port RAM with one write port and one registered read port. Address bit 8 selects the page.

## Test plan
- Fill one macroblock with `din`=`yaddr`, then pulse `start` -> 256 samples.
  - `dout` sequence starts 00,01,..,07,10,..,77, then 08..0F,..., then 80.., then 88.., ending FF.
  - `first_out` at cycle 2, `last_out` at cycle 257.
- Fill 2 macroblocks without reading -> `ready`=1 and `full`=2'b11. A third macroblock -> dropped, `overrun`=1, `overrun_cnt`=1 (macro on).
  - Then drain twice -> first and second macroblocks' data in order.
- Start draining page 0 while page 1 fills, with completions landing in the same cycle as the read-page release -> no drop, and the next `ready` presents page 1.
- Assert `rst` during READ at sample 100 -> `dv`=0 the next cycle, all outputs at reset values, `overrun` cleared.
- Pulse `en`=0 mid-write (`yaddr`=8'h40) -> partial data discarded, `ready` stays 0. A following full macroblock drains correctly.
- Pulse `start` with `ready`=0, and during READ -> ignored, no extra `dv` cycles.

Source files
------------

// File: rtl/mb2blk_pkg.sv
// Shared types and constants for the macroblock-to-8x8-block reorder buffer.
// Read-address helper maps a linear drain counter onto the page layout.
package mb2blk_pkg;

   localparam int MB_SAMPLES = 256;
   localparam int BLK_SIDE   = 8;
   localparam int PAGES      = 2;

   localparam logic [7:0] LAST_IDX = 8'(MB_SAMPLES - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      FLUSH = 2'd2
   } rd_state_t;

   // cnt = {blk[1:0], row[2:0], col[2:0]} -> {page, blk[1], row, blk[0], col}
   function automatic logic [8:0] rd_addr(input logic page,
                                          input logic [7:0] cnt);
      return {page, cnt[7], cnt[5:3], cnt[6], cnt[2:0]};
   endfunction

endpackage

// File: rtl/ram_512x8_w1r1.sv
// Two-page sample store: one write port, one registered read port.
// Address bit 8 selects the page; clr zeroes the read register.
module ram_512x8_w1r1
   import mb2blk_pkg::*;
(
   input  logic       clk,
   input  logic       clr,
   input  logic       we,
   input  logic [8:0] waddr,
   input  logic [7:0] wdata,
   input  logic       re,
   input  logic [8:0] raddr,
   output logic [7:0] rdata
);

   logic [7:0] mem [0:PAGES*MB_SAMPLES-1];

   // write port
   always_ff @(posedge clk) begin
      if (we)
         mem[waddr] <= wdata;
   end

   // registered read port, cleared with the block
   always_ff @(posedge clk) begin
      if (clr)
         rdata <= 8'h00;
      else if (re)
         rdata <= mem[raddr];
   end

endmodule

// File: rtl/mb_to_blocks_mono.sv
// Captures 16x16 Y macroblocks into a two-page buffer and replays each as
// four 8x8 row-major blocks. Optional MB2BLK_OVERRUN_CNT_EN adds overrun_cnt.
module mb_to_blocks_mono
   import mb2blk_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic       pre_first_in,
   input  logic [7:0] din,
   input  logic [7:0] yaddr,
   input  logic       ywe,
   output logic       ready,
   input  logic       start,
   output logic [7:0] dout,
   output logic       dv,
   output logic       first_out,
   output logic       last_out,
   output logic       busy,
   output logic       overrun
`ifdef MB2BLK_OVERRUN_CNT_EN
   ,
   output logic [7:0] overrun_cnt
`endif
);

   rd_state_t  state;
   rd_state_t  state_nx;
   logic [1:0] full;
   logic       wpage;
   logic       rpage;
   logic       drop;
   logic       drop_eff;
   logic       clr;
   logic       wr_ok;
   logic       wr_done;
   logic       rd_done;
   logic       mb_lost;
   logic       re;
   logic [8:0] raddr;
   logic [7:0] rcnt;

   assign clr = rst | ~en;

   // the first sample of a macroblock must already see the new drop decision
   always_comb begin
      drop_eff = drop;
      if (pre_first_in)
         drop_eff = full[wpage];
   end

   assign wr_ok   = en & ywe & ~drop_eff;
   assign wr_done = wr_ok & (yaddr == LAST_IDX);
   assign rd_done = (state == READ) & (rcnt == LAST_IDX);
   assign mb_lost = en & pre_first_in & full[wpage];

   // page bookkeeping: fill completes on one page while drain frees the other
   always_ff @(posedge clk) begin
      if (clr) begin
         full  <= 2'b00;
         wpage <= 1'b0;
         rpage <= 1'b0;
         drop  <= 1'b0;
      end else begin
         if (pre_first_in)
            drop <= full[wpage];
         if (ywe && yaddr == LAST_IDX && drop_eff)
            drop <= 1'b0;
         if (wr_done) begin
            full[wpage] <= 1'b1;
            wpage       <= ~wpage;
         end
         if (rd_done) begin
            full[rpage] <= 1'b0;
            rpage       <= ~rpage;
         end
      end
   end

   // sticky drop flag survives en=0
   always_ff @(posedge clk) begin
      if (rst)
         overrun <= 1'b0;
      else if (mb_lost)
         overrun <= 1'b1;
   end

`ifdef MB2BLK_OVERRUN_CNT_EN
   // saturating count of dropped macroblocks
   always_ff @(posedge clk) begin
      if (rst)
         overrun_cnt <= 8'h00;
      else if (mb_lost && overrun_cnt != 8'hff)
         overrun_cnt <= overrun_cnt + 8'd1;
   end
`endif

   // reader state register
   always_ff @(posedge clk) begin
      if (clr)
         state <= IDLE;
      else
         state <= state_nx;
   end

   // reader next-state logic
   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE: begin
            if (start && full[rpage])
               state_nx = READ;
         end
         READ: begin
            if (rcnt == LAST_IDX)
               state_nx = FLUSH;
         end
         FLUSH: state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // reader outputs and RAM read request
   always_comb begin
      ready = (state == IDLE) & full[rpage];
      busy  = (state != IDLE);
      re    = (state == READ);
      raddr = rd_addr(rpage, rcnt);
   end

   // drain counter: held at zero while idle
   always_ff @(posedge clk) begin
      if (clr)
         rcnt <= 8'h00;
      else if (state == READ)
         rcnt <= rcnt + 8'd1;
      else
         rcnt <= 8'h00;
   end

   // valid and framing flags track the one-cycle RAM latency
   always_ff @(posedge clk) begin
      if (clr) begin
         dv        <= 1'b0;
         first_out <= 1'b0;
         last_out  <= 1'b0;
      end else begin
         dv        <= re;
         first_out <= re & (rcnt == 8'h00);
         last_out  <= re & (rcnt == LAST_IDX);
      end
   end

   ram_512x8_w1r1 u_ram (
      .clk   (clk),
      .clr   (clr),
      .we    (wr_ok),
      .waddr ({wpage, yaddr}),
      .wdata (din),
      .re    (re),
      .raddr (raddr),
      .rdata (dout)
   );

endmodule

// File: tb/tb_mb_to_blocks_mono.sv
// Scoreboard bench for mb_to_blocks_mono: fills, drains, drops,
// concurrent fill/drain, reset and enable aborts.
module tb_mb_to_blocks_mono;

   logic       clk = 1'b0;
   logic       rst;
   logic       en;
   logic       pre_first_in;
   logic [7:0] din;
   logic [7:0] yaddr;
   logic       ywe;
   logic       ready;
   logic       start;
   logic [7:0] dout;
   logic       dv;
   logic       first_out;
   logic       last_out;
   logic       busy;
   logic       overrun;
`ifdef MB2BLK_OVERRUN_CNT_EN
   logic [7:0] overrun_cnt;
`endif

   mb_to_blocks_mono dut (
      .clk          (clk),
      .rst          (rst),
      .en           (en),
      .pre_first_in (pre_first_in),
      .din          (din),
      .yaddr        (yaddr),
      .ywe          (ywe),
      .ready        (ready),
      .start        (start),
      .dout         (dout),
      .dv           (dv),
      .first_out    (first_out),
      .last_out     (last_out),
      .busy         (busy),
      .overrun      (overrun)
`ifdef MB2BLK_OVERRUN_CNT_EN
      ,
      .overrun_cnt  (overrun_cnt)
`endif
   );

   always #5 clk = ~clk;

   typedef logic [9:0] exp_t;

   int         n_chk = 0;
   int         n_fail = 0;
   int         cyc = 0;
   exp_t       expq[$];
   int         pend[$];
   int         nfull = 0;
   logic       exp_ovr = 1'b0;
   int         exp_cnt = 0;
   int         first_cyc = -1;
   int         last_cyc = -1;
   int         nsamp = 0;
   int         didx = 0;
   logic [7:0] cap [256];
   exp_t       e_mon;

   always @(posedge clk) cyc++;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] smp(input int a, input int seed);
      return 8'(a + seed * 37);
   endfunction

   // output monitor: every valid sample is popped and compared
   always @(negedge clk) begin
      if (dv === 1'b1) begin
         if (first_out === 1'b1) begin
            first_cyc = cyc;
            didx = 0;
         end
         if (last_out === 1'b1)
            last_cyc = cyc;
         if (didx < 256)
            cap[didx] = dout;
         didx++;
         nsamp++;
         if (expq.size() == 0)
            chk("extra_dv", 32'd1, 32'd0);
         else begin
            e_mon = expq.pop_front();
            chk("sample", {22'd0, first_out, last_out, dout},
                {22'd0, e_mon});
         end
      end
   end

   task automatic push_exp(input int seed);
      logic [7:0] kk;
      int a;
      for (int k = 0; k < 256; k++) begin
         kk = 8'(k);
         a = int'({kk[7], kk[5:3], kk[6], kk[2:0]});
         expq.push_back({k == 0, k == 255, smp(a, seed)});
      end
   endtask

   task automatic fill(input int seed, input int stop_at,
                       input bit chk_rdy);
      bit drop;
      drop = (nfull == 2);
      if (drop) begin
         exp_ovr = 1'b1;
         if (exp_cnt < 255)
            exp_cnt++;
      end
      for (int a = 0; a < 256; a++) begin
         @(posedge clk);
         #1;
         pre_first_in = (a == 0);
         ywe = 1'b1;
         yaddr = 8'(a);
         din = smp(a, seed);
         if (a == stop_at) begin
            en = 1'b0;
            @(posedge clk);
            #1;
            en = 1'b1;
            ywe = 1'b0;
            pre_first_in = 1'b0;
            nfull = 0;
            pend.delete();
            return;
         end
      end
      @(posedge clk);
      #1;
      ywe = 1'b0;
      pre_first_in = 1'b0;
      if (!drop) begin
         nfull++;
         pend.push_back(seed);
         if (chk_rdy)
            chk("ready_lat", 32'(ready), 32'd1);
      end
      chk("overrun", 32'(overrun), 32'(exp_ovr));
`ifdef MB2BLK_OVERRUN_CNT_EN
      chk("overrun_cnt", 32'(overrun_cnt), 32'(exp_cnt));
`endif
   endtask

   task automatic drain(input bit mid_start, input bit rdy_after);
      int s;
      int s_cyc;
      if (pend.size() == 0) begin
         chk("drain_pending", 32'd0, 32'd1);
         return;
      end
      s = pend.pop_front();
      push_exp(s);
      @(posedge clk);
      #1;
      chk("ready_pre", 32'(ready), 32'd1);
      start = 1'b1;
      s_cyc = cyc;
      @(posedge clk);
      #1;
      start = 1'b0;
      chk("busy_c1", 32'(busy), 32'd1);
      if (mid_start) begin
         repeat (50) @(posedge clk);
         #1;
         start = 1'b1;
         @(posedge clk);
         #1;
         start = 1'b0;
      end
      while (cyc < s_cyc + 258) begin
         @(posedge clk);
         #1;
      end
      chk("busy_c258", 32'(busy), 32'd0);
      chk("ready_c258", 32'(ready), 32'(rdy_after));
      chk("first_cyc", 32'(first_cyc - s_cyc), 32'd2);
      chk("last_cyc", 32'(last_cyc - s_cyc), 32'd257);
      chk("exp_left", 32'(expq.size()), 32'd0);
      nfull--;
   endtask

   initial begin
      int base;
      int t;
      rst = 1'b1;
      en = 1'b1;
      pre_first_in = 1'b0;
      din = 8'h00;
      yaddr = 8'h00;
      ywe = 1'b0;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ready", 32'(ready), 32'd0);
      chk("rst_dout", 32'(dout), 32'd0);
      chk("rst_dv", 32'(dv), 32'd0);
      chk("rst_first", 32'(first_out), 32'd0);
      chk("rst_last", 32'(last_out), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_overrun", 32'(overrun), 32'd0);
      rst = 1'b0;

      // single macroblock, din = yaddr
      fill(0, -1, 1);
      drain(0, 0);
      chk("seq_0", 32'(cap[0]), 32'h00);
      chk("seq_8", 32'(cap[8]), 32'h10);
      chk("seq_63", 32'(cap[63]), 32'h77);
      chk("seq_64", 32'(cap[64]), 32'h08);
      chk("seq_128", 32'(cap[128]), 32'h80);
      chk("seq_192", 32'(cap[192]), 32'h88);
      chk("seq_255", 32'(cap[255]), 32'hff);

      // start while not ready is ignored
      @(posedge clk);
      #1;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      chk("idle_start", 32'(busy), 32'd0);
      repeat (4) @(posedge clk);

      // two pages full, third dropped, drained in order
      fill(1, -1, 1);
      fill(2, -1, 1);
      fill(3, -1, 0);
      chk("ready_full", 32'(ready), 32'd1);
      drain(1, 1);
      drain(0, 0);

      // fill page 1 while page 0 drains; completion meets release
      fill(4, -1, 1);
      fork
         drain(0, 1);
         begin
            @(posedge clk);
            fill(5, -1, 0);
         end
      join
      drain(0, 0);

      // reset in the middle of a drain
      fill(6, -1, 1);
      s_start_mid: begin
         push_exp(pend.pop_front());
         base = nsamp;
         @(posedge clk);
         #1;
         start = 1'b1;
         @(posedge clk);
         #1;
         start = 1'b0;
         t = 0;
         while (nsamp < base + 100 && t < 400) begin
            @(posedge clk);
            #1;
            t++;
         end
         chk("rst_wait", 32'(nsamp >= base + 100), 32'd1);
         rst = 1'b1;
         @(posedge clk);
         #1;
         expq.delete();
         pend.delete();
         nfull = 0;
         exp_ovr = 1'b0;
         exp_cnt = 0;
         @(negedge clk);
         chk("mid_rst_dv", 32'(dv), 32'd0);
         chk("mid_rst_dout", 32'(dout), 32'd0);
         chk("mid_rst_flags", 32'({first_out, last_out}), 32'd0);
         chk("mid_rst_busy", 32'(busy), 32'd0);
         chk("mid_rst_ready", 32'(ready), 32'd0);
         chk("mid_rst_ovr", 32'(overrun), 32'd0);
`ifdef MB2BLK_OVERRUN_CNT_EN
         chk("mid_rst_cnt", 32'(overrun_cnt), 32'd0);
`endif
         @(posedge clk);
         #1;
         rst = 1'b0;
      end

      // enable pulse aborts a partial macroblock
      fill(7, 'h40, 0);
      repeat (3) @(posedge clk);
      #1;
      chk("abort_ready", 32'(ready), 32'd0);
      chk("abort_busy", 32'(busy), 32'd0);
      fill(8, -1, 1);
      drain(0, 0);

      repeat (5) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
